// File: rtl/pc_pkg.sv
// Shared opcode encodings for the MIPS16e program-counter unit.
package pc_pkg;
    localparam int PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        PC_NOP    = 3'd0,
        PC_INC    = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JUMP   = 3'd3,
        PC_CALL   = 3'd4,
        PC_RET    = 3'd5
    } pc_op_e;
endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module ras_stack #(
    parameter int WORD_SIZE = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WORD_SIZE-1:0] din,
    output logic [WORD_SIZE-1:0] top,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int OW = PW + 1;

    logic [RAS_DEPTH-1:0][WORD_SIZE-1:0] mem_q;
    logic [PW-1:0]                       tp_q, tp_d, tp_inc;
    logic [OW-1:0]                       occ_q, occ_d;

    assign tp_inc    = tp_q + PW'(1);
    assign empty     = (occ_q == '0);
    assign full      = (occ_q == OW'(RAS_DEPTH));
    assign overflow  = push & full;
    assign underflow = pop & ~push & empty;
    assign top       = empty ? '0 : mem_q[tp_q];

    // The slot after the top is the oldest one once full, so the wrap overwrites it.
    always_comb begin
        tp_d  = tp_q;
        occ_d = occ_q;
        if (push) begin
            tp_d = tp_inc;
            if (!full) occ_d = occ_q + OW'(1);
        end else if (pop && !empty) begin
            tp_d  = tp_q - PW'(1);
            occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
            tp_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push) mem_q[tp_inc] <= din;
            tp_q  <= tp_d;
            occ_q <= occ_d;
        end
    end
endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/jump/call/return and an internal return-address stack.
// Optional exception entry/return is enabled by defining PC_EXC_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                   WORD_SIZE   = 16,
    parameter int                   OFFSET_SIZE = 11,
    parameter int                   INC_STEP    = 1,
    parameter logic [WORD_SIZE-1:0] RESET_VEC   = '0,
    parameter int                   RAS_DEPTH   = 4
`ifdef PC_EXC_EN
   ,parameter logic [WORD_SIZE-1:0] EXC_VEC     = 16'h0004
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef PC_EXC_EN
    input  logic                   exc,
    input  logic                   eret,
    output logic [WORD_SIZE-1:0]   epc,
`endif
    input  logic                   stall,
    input  logic [PC_OP_W-1:0]     op,
    input  logic [OFFSET_SIZE-1:0] offset,
    input  logic [WORD_SIZE-1:0]   target,
    output logic [WORD_SIZE-1:0]   count,
    output logic [WORD_SIZE-1:0]   link,
    output logic                   ras_empty,
    output logic                   ras_full,
    output logic                   ras_err
);
    localparam logic [WORD_SIZE-1:0] STEP = WORD_SIZE'(INC_STEP);

    logic [WORD_SIZE-1:0] count_q, count_d, seq_pc, br_off;
    logic                 err_q, err_d;
    logic                 push, pop, ovf, unf;

    assign seq_pc = count_q + STEP;
    assign br_off = {{(WORD_SIZE-OFFSET_SIZE){offset[OFFSET_SIZE-1]}}, offset};

    ras_stack #(.WORD_SIZE(WORD_SIZE), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(seq_pc),
        .top(link), .empty(ras_empty), .full(ras_full),
        .overflow(ovf), .underflow(unf)
    );

`ifdef PC_EXC_EN
    logic [WORD_SIZE-1:0] epc_q, epc_d;
`endif

    always_comb begin
        count_d = count_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (!stall) begin
            case (op)
                PC_INC:    count_d = seq_pc;
                PC_BRANCH: count_d = count_q + br_off;
                PC_JUMP:   count_d = target;
                PC_CALL: begin
                    push    = 1'b1;
                    count_d = target;
                end
                PC_RET: begin
                    pop     = 1'b1;
                    count_d = ras_empty ? seq_pc : link;
                end
                default:   count_d = count_q;
            endcase
        end
`ifdef PC_EXC_EN
        epc_d = epc_q;
        // Exception entry/return suppress the op entirely, including stack traffic.
        if (!stall && eret) begin
            count_d = epc_q;
            push    = 1'b0;
            pop     = 1'b0;
        end
        if (exc) begin
            epc_d   = count_q;
            count_d = EXC_VEC;
            push    = 1'b0;
            pop     = 1'b0;
        end
`endif
        err_d = ovf | unf;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RESET_VEC;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

`ifdef PC_EXC_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) epc_q <= '0;
        else      epc_q <= epc_d;
    end
    assign epc = epc_q;
`endif

    assign count   = count_q;
    assign ras_err = err_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: queue-based reference model checked every cycle, plus literal pins.
module tb_pc_unit;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [10:0] offset = '0;
    logic [15:0] target = '0;
    logic [15:0] count, link;
    logic        ras_empty, ras_full, ras_err;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .op(op), .offset(offset),
        .target(target), .count(count), .link(link),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: PC as an integer, stack as a queue (back = most recent).
    int          m_cnt;
    int          m_stk[$];
    bit          m_err;

    task automatic cmp(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    task automatic model_apply(input logic [2:0] o, input logic [10:0] off,
                               input logic [15:0] tgt, input logic st);
        int so;
        m_err = 1'b0;
        if (st) return;
        case (o)
            3'd1: m_cnt = (m_cnt + 1) % 65536;
            3'd2: begin
                so    = (off >= 11'd1024) ? int'(off) - 2048 : int'(off);
                m_cnt = (m_cnt + so + 65536) % 65536;
            end
            3'd3: m_cnt = tgt;
            3'd4: begin
                m_stk.push_back((m_cnt + 1) % 65536);
                if (m_stk.size() > 4) begin
                    void'(m_stk.pop_front());
                    m_err = 1'b1;
                end
                m_cnt = tgt;
            end
            3'd5: begin
                if (m_stk.size() > 0) m_cnt = m_stk.pop_back();
                else begin
                    m_cnt = (m_cnt + 1) % 65536;
                    m_err = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("count", int'(count), m_cnt);
            cmp("link", int'(link), (m_stk.size() > 0) ? m_stk[$] : 0);
            cmp("ras_empty", int'(ras_empty), int'(m_stk.size() == 0));
            cmp("ras_full", int'(ras_full), int'(m_stk.size() == 4));
            cmp("ras_err", int'(ras_err), int'(m_err));
        end
    end

    // Drive just after the falling edge; results are visible 1 time unit after the rising edge.
    task automatic step(input logic [2:0] o, input logic [10:0] off = '0,
                        input logic [15:0] tgt = '0, input logic st = 1'b0);
        @(negedge clk);
        #2;
        op = o; offset = off; target = tgt; stall = st;
        model_apply(o, off, tgt, st);
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        chk_en = 1'b1;
        #1;
        cmp("reset_count", int'(count), 0);
        cmp("reset_empty", int'(ras_empty), 1);
        cmp("reset_err", int'(ras_err), 0);

        repeat (3) step(PC_INC);
        cmp("inc3_count", int'(count), 3);
        cmp("inc3_empty", int'(ras_empty), 1);

        // Asynchronous reset in the middle of the high phase.
        #2 rst = 1'b0;
        model_reset();
        #1 cmp("async_reset_count", int'(count), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        op = PC_NOP;

        step(PC_JUMP, '0, 16'h0010);
        step(PC_BRANCH, 11'h7FE);
        cmp("branch_neg", int'(count), 16'h000E);
        step(PC_BRANCH, 11'h005);
        cmp("branch_pos", int'(count), 16'h0013);
        step(3'd6);
        cmp("reserved_hold", int'(count), 16'h0013);
        step(PC_JUMP, '0, 16'hFFFF);
        step(PC_INC);
        cmp("inc_wrap", int'(count), 16'h0000);

        step(PC_JUMP, '0, 16'h0020);
        step(PC_CALL, '0, 16'h0100);
        cmp("call1_count", int'(count), 16'h0100);
        cmp("call1_link", int'(link), 16'h0021);
        step(PC_CALL, '0, 16'h0200);
        cmp("call2_link", int'(link), 16'h0101);
        step(PC_RET);
        cmp("ret1_count", int'(count), 16'h0101);
        step(PC_RET);
        cmp("ret2_count", int'(count), 16'h0021);
        cmp("ret2_empty", int'(ras_empty), 1);

        // Overflow: five calls into a four-deep stack.
        step(PC_JUMP, '0, 16'h0030);
        for (int i = 0; i < 5; i++) begin
            step(PC_CALL, '0, 16'(16'h0040 + 16 * i));
            if (i == 3) cmp("call4_err", int'(ras_err), 0);
        end
        cmp("call5_full", int'(ras_full), 1);
        cmp("call5_err", int'(ras_err), 1);
        cmp("call5_link", int'(link), 16'h0071);
        step(PC_RET); cmp("lifo1", int'(count), 16'h0071);
        step(PC_RET); cmp("lifo2", int'(count), 16'h0061);
        step(PC_RET); cmp("lifo3", int'(count), 16'h0051);
        step(PC_RET); cmp("lifo4", int'(count), 16'h0041);
        cmp("lifo_err", int'(ras_err), 0);
        step(PC_RET);
        cmp("underflow_count", int'(count), 16'h0042);
        cmp("underflow_err", int'(ras_err), 1);

        // Stalled CALL must not execute until released, then only once.
        repeat (3) step(PC_CALL, '0, 16'h0090, 1'b1);
        cmp("stall_count", int'(count), 16'h0042);
        cmp("stall_empty", int'(ras_empty), 1);
        step(PC_CALL, '0, 16'h0090);
        cmp("release_count", int'(count), 16'h0090);
        cmp("release_link", int'(link), 16'h0043);
        step(PC_NOP);
        cmp("release_once", int'(link), 16'h0043);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
